// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - controller <-> multiply/divide unit signal bundle
interface mul_div_unit_if;
    logic        start;
    logic [2:0]  MDop;
    logic        HIwrite;
    logic        LOwrite;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    // Controller side: issues operations and mthi/mtlo, reads busy and HI/LO.
    modport master (
        output start, MDop, HIwrite, LOwrite, A, B,
        input  busy, HI, LO
    );

    // Unit side.
    modport slave (
        input  start, MDop, HIwrite, LOwrite, A, B,
        output busy, HI, LO
    );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - E-stage multiply/divide unit with HI/LO; optional msub via MDU_MSUB_EN
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    mul_div_unit_if.slave mdu
);

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MSUB  = 3'b100;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [2:0]         r_op;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;

    logic               w_start_valid;
    logic               w_start_div;
    logic               w_is_div;
    logic               w_div_by_zero;
    logic [63:0]        w_prod_u;
    logic signed [63:0] w_prod_s;
    logic               w_signed_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [31:0]        w_a_mag;
    logic [31:0]        w_b_mag;
    logic [31:0]        w_q_mag;
    logic [31:0]        w_r_mag;
    logic [31:0]        w_quo;
    logic [31:0]        w_rem;
    logic [63:0]        w_res;

    // Decode which incoming opcodes launch an operation; msub is only legal when built in.
    always_comb begin
        w_start_valid = 1'b0;
        case (mdu.MDop)
            OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: w_start_valid = 1'b1;
`ifdef MDU_MSUB_EN
            OP_MSUB:                            w_start_valid = 1'b1;
`endif
            default:                            w_start_valid = 1'b0;
        endcase
    end

    assign w_start_div   = (mdu.MDop == OP_DIVU) || (mdu.MDop == OP_DIV);
    assign w_is_div      = (r_op == OP_DIVU) || (r_op == OP_DIV);
    assign w_div_by_zero = w_is_div && (r_b == 32'd0);

    // Products from the latched operands; both are 64x64 so the low 64 bits are exact.
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});

    // Signed divide runs on magnitudes so that 0x80000000 / -1 needs no special case:
    // its magnitude quotient 0x80000000 is already the wrapped two's-complement answer.
    assign w_signed_div = (r_op == OP_DIV);
    assign w_a_neg      = w_signed_div & r_a[31];
    assign w_b_neg      = w_signed_div & r_b[31];
    assign w_a_mag      = w_a_neg ? (~r_a + 32'd1) : r_a;
    assign w_b_mag      = w_b_neg ? (~r_b + 32'd1) : r_b;
    assign w_q_mag      = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag / w_b_mag);
    assign w_r_mag      = (w_b_mag == 32'd0) ? 32'd0 : (w_a_mag % w_b_mag);
    assign w_quo        = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_rem        = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    // Pending {HI,LO} result, derived purely from latched state so it is stable while busy.
    always_comb begin
        w_res = {r_hi, r_lo};
        case (r_op)
            OP_MULTU: w_res = w_prod_u;
            OP_MULT:  w_res = w_prod_s;
            OP_DIVU,
            OP_DIV:   w_res = {w_rem, w_quo};
`ifdef MDU_MSUB_EN
            OP_MSUB:  w_res = {r_hi, r_lo} - w_prod_s;
`endif
            default:  w_res = {r_hi, r_lo};
        endcase
    end

    // Idle/busy sequencer: launch, count down, commit HI/LO on the final edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 3'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (mdu.start && w_start_valid) begin
                        r_a     <= mdu.A;
                        r_b     <= mdu.B;
                        r_op    <= mdu.MDop;
                        r_cnt   <= w_start_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        r_state <= ST_BUSY;
                    end else begin
                        if (mdu.HIwrite) r_hi <= mdu.A;
                        if (mdu.LOwrite) r_lo <= mdu.A;
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                        // A zero divisor burns the full latency but leaves HI/LO alone.
                        if (!w_div_by_zero) begin
                            r_hi <= w_res[63:32];
                            r_lo <= w_res[31:0];
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mdu.busy = (r_state == ST_BUSY);
    assign mdu.HI   = r_hi;
    assign mdu.LO   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit
module tb_mul_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic clk;
    logic reset;

    mul_div_unit_if bus ();

    mul_div_unit #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    logic [63:0] sb_q[$];
    logic [63:0] m_hl;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model computed in 64-bit integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'b000: return {32'd0, a} * {32'd0, b};
            3'b001: return sa * sb;
            3'b010: begin
                if (b == 32'd0) return hl;
                return {a % b, a / b};
            end
            3'b011: begin
                if (b == 32'd0) return hl;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'b100: return hl - (sa * sb);
            default: return hl;
        endcase
    endfunction

    task automatic set_hl(input logic [31:0] hi, input logic [31:0] lo);
        @(negedge clk);
        bus.HIwrite = 1'b1; bus.A = hi;
        @(negedge clk);
        bus.HIwrite = 1'b0; bus.LOwrite = 1'b1; bus.A = lo;
        @(negedge clk);
        bus.LOwrite = 1'b0; bus.A = 32'd0;
        m_hl = {hi, lo};
        check("preset_hl", {bus.HI, bus.LO}, m_hl);
    endtask

    // Launch an op, push its expected result, measure busy length, then pop and compare.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int n,
                          input bit noise);
        int cnt;
        logic [63:0] e;
        sb_q.push_back(exp);
        @(negedge clk);
        bus.start = 1'b1; bus.MDop = op; bus.A = a; bus.B = b;
        @(negedge clk);
        bus.start = 1'b0; bus.A = 32'd0; bus.B = 32'd0;
        cnt = 0;
        while (bus.busy && cnt < 200) begin
            cnt++;
            if (noise && cnt == 2) begin
                bus.start = 1'b1; bus.MDop = 3'b000; bus.A = 32'hDEAD; bus.B = 32'd3;
                bus.HIwrite = 1'b1; bus.LOwrite = 1'b1;
            end else begin
                bus.start = 1'b0; bus.HIwrite = 1'b0; bus.LOwrite = 1'b0;
                bus.A = 32'd0; bus.B = 32'd0;
            end
            @(negedge clk);
        end
        bus.start = 1'b0; bus.HIwrite = 1'b0; bus.LOwrite = 1'b0;
        check({tag, "_busy_cycles"}, 64'(cnt), 64'(n));
        e = sb_q.pop_front();
        check({tag, "_hilo"}, {bus.HI, bus.LO}, e);
        m_hl = e;
    endtask

    initial begin
        bit seen_busy;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        n_checks = 0;
        n_fail   = 0;
        m_hl     = 64'd0;
        reset = 1'b0;
        bus.start = 1'b0; bus.MDop = 3'b000; bus.HIwrite = 1'b0; bus.LOwrite = 1'b0;
        bus.A = 32'd0; bus.B = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_hilo", {bus.HI, bus.LO}, 64'd0);
        reset = 1'b1;

        // Asynchronous reset while a divide is in flight (counter at 4).
        set_hl(32'h55, 32'h66);
        @(negedge clk);
        bus.start = 1'b1; bus.MDop = 3'b011; bus.A = 32'd100; bus.B = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (6) @(negedge clk);
        check("middiv_busy_before", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        #1;
        check("middiv_busy_after", 64'(bus.busy), 64'd0);
        check("middiv_hilo_after", {bus.HI, bus.LO}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hl = 64'd0;
        @(negedge clk);
        bus.HIwrite = 1'b1; bus.A = 32'h12345678;
        @(negedge clk);
        bus.HIwrite = 1'b0; bus.A = 32'd0;
        check("mthi_after_reset", {bus.HI, bus.LO}, {32'h12345678, 32'd0});

        // Directed arithmetic vectors.
        run_op("mult_m2x3",  3'b001, 32'hFFFFFFFE, 32'd3, {32'hFFFFFFFF, 32'hFFFFFFFA}, MULT_N, 1'b0);
        run_op("multu_m2x3", 3'b000, 32'hFFFFFFFE, 32'd3, {32'h00000002, 32'hFFFFFFFA}, MULT_N, 1'b0);
        run_op("div_m7d2",   3'b011, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, DIV_N, 1'b0);
        run_op("divu_100d7", 3'b010, 32'd100, 32'd7, {32'd2, 32'd14}, DIV_N, 1'b0);
        run_op("div_ovf",    3'b011, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, DIV_N, 1'b0);
        run_op("div_7dm2",   3'b011, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, DIV_N, 1'b0);

        // Divide by zero keeps HI/LO.
        set_hl(32'h11, 32'h22);
        run_op("divu_by0", 3'b010, 32'd1234, 32'd0, {32'h11, 32'h22}, DIV_N, 1'b0);
        run_op("div_by0",  3'b011, 32'hFFFF0000, 32'd0, {32'h11, 32'h22}, DIV_N, 1'b0);

        // Optional msub.
        set_hl(32'd0, 32'd10);
`ifdef MDU_MSUB_EN
        run_op("msub", 3'b100, 32'd3, 32'd4, model(3'b100, 32'd3, 32'd4, m_hl), MULT_N, 1'b0);
`else
        @(negedge clk);
        bus.start = 1'b1; bus.MDop = 3'b100; bus.A = 32'd3; bus.B = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        seen_busy = 1'b0;
        repeat (MULT_N + 1) begin
            if (bus.busy) seen_busy = 1'b1;
            @(negedge clk);
        end
        check("msub_off_busy", 64'(seen_busy), 64'd0);
        check("msub_off_hilo", {bus.HI, bus.LO}, {32'd0, 32'd10});
`endif
        // Invalid opcode is ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.MDop = 3'b111; bus.A = 32'd9; bus.B = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        check("invalid_op_busy", 64'(bus.busy), 64'd0);

        // Writes and start during busy are ignored.
        run_op("noise_mult", 3'b001, 32'd7, 32'hFFFFFFFB, {32'hFFFFFFFF, 32'hFFFFFFDD}, MULT_N, 1'b1);

        // Randomised ops against the model.
        for (int i = 0; i < 10; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            run_op("rand", rop, ra, rb, model(rop, ra, rb, m_hl),
                   (rop[1] ? DIV_N : MULT_N), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
